// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory arbiter: datapath widths and the
//   arbiter FSM state encoding.
package mem_arbiter_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned WMASK_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates an instruction-fetch port and a load/store port onto a single
//   shared memory bus. At most one transaction is in flight. Data requests
//   have priority over fetches. When MEM_ARB_STARVE_GUARD_EN is defined, a
//   streak counter forces a fetch grant after STARVE_LIMIT consecutive data
//   completions while a fetch was waiting.
//
// Ports
//   clk_in, rst_n_in              clock, async active-low reset
//   ifetch_valid_in/addr_in       fetch request (held until ifetch_ready_out)
//   ifetch_ready_out/rdata_out    fetch completion pulse and read data
//   data_valid_in/addr_in/write_in/wdata_in/wmask_in
//                                 load/store request (held until data_ready_out)
//   data_ready_out/rdata_out      load/store completion pulse and load data
//   bus_valid_out/addr_out/write_out/wdata_out/wmask_out
//                                 registered shared-bus request
//   bus_ready_in/rdata_in         shared-bus completion and read data
//
// Configuration
//   MEM_ARB_STARVE_GUARD_EN       enables the fetch starvation guard
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               ifetch_valid_in,
  input  logic [XLEN-1:0]    ifetch_addr_in,
  output logic               ifetch_ready_out,
  output logic [XLEN-1:0]    ifetch_rdata_out,
  input  logic               data_valid_in,
  input  logic [XLEN-1:0]    data_addr_in,
  input  logic               data_write_in,
  input  logic [XLEN-1:0]    data_wdata_in,
  input  logic [WMASK_W-1:0] data_wmask_in,
  output logic               data_ready_out,
  output logic [XLEN-1:0]    data_rdata_out,
  output logic               bus_valid_out,
  output logic [XLEN-1:0]    bus_addr_out,
  output logic               bus_write_out,
  output logic [XLEN-1:0]    bus_wdata_out,
  output logic [WMASK_W-1:0] bus_wmask_out,
  input  logic               bus_ready_in,
  input  logic [XLEN-1:0]    bus_rdata_in
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_limit_check
    $error("mem_arbiter: STARVE_LIMIT must be in 1..7");
  end

  arb_state_t state;
  logic       grant_data;
  logic       grant_fetch;
  logic       starve;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] streak;

  assign starve = ifetch_valid_in && data_valid_in &&
                  (streak == 3'(STARVE_LIMIT));

  // Counts data completions that happened while a fetch was waiting;
  // any cycle without a pending fetch breaks the streak.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      streak <= '0;
    end else if (!ifetch_valid_in || grant_fetch) begin
      streak <= '0;
    end else if (state == DATA && bus_ready_in &&
                 streak < 3'(STARVE_LIMIT)) begin
      streak <= streak + 3'd1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    if (state == IDLE) begin
      if (data_valid_in && !starve) begin
        grant_data = 1'b1;
      end else if (ifetch_valid_in) begin
        grant_fetch = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      bus_valid_out <= 1'b0;
      bus_addr_out  <= '0;
      bus_write_out <= 1'b0;
      bus_wdata_out <= '0;
      bus_wmask_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data) begin
            state         <= DATA;
            bus_valid_out <= 1'b1;
            bus_addr_out  <= data_addr_in;
            bus_write_out <= data_write_in;
            bus_wdata_out <= data_wdata_in;
            bus_wmask_out <= data_wmask_in;
          end else if (grant_fetch) begin
            state         <= FETCH;
            bus_valid_out <= 1'b1;
            bus_addr_out  <= ifetch_addr_in;
            bus_write_out <= 1'b0;
            bus_wdata_out <= '0;
            bus_wmask_out <= '0;
          end
        end
        FETCH, DATA: begin
          // Bus fields stay frozen until the bus accepts the transaction.
          if (bus_ready_in) begin
            state         <= IDLE;
            bus_valid_out <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus_valid_out <= 1'b0;
        end
      endcase
    end
  end

  assign ifetch_ready_out = (state == FETCH) && bus_ready_in;
  assign data_ready_out   = (state == DATA)  && bus_ready_in;
  assign ifetch_rdata_out = bus_rdata_in;
  assign data_rdata_out   = bus_rdata_in;

endmodule
